// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that lets four requesters share one seven-segment display path.
// A new owner keeps the display for at least HOLD_CYCLES cycles. Handover is glitch-free.
module seg_display_arbiter #(
  parameter int          WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 32'd100000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_value,
  input  logic [3:0]         req_mode,
  output logic [3:0]         grant,
  output logic [WIDTH-1:0]   disp_value,
  output logic               disp_mode,
  output logic               disp_valid,
  output logic               switch_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 32'd1);

  state_t             state_r, state_next_s;
  logic [31:0]        cnt_r, cnt_next_s;
  logic [1:0]         ptr_r, ptr_next_s;
  logic [3:0]         grant_r, grant_next_s;
  logic [WIDTH-1:0]   value_r, value_next_s;
  logic               mode_r, mode_next_s;
  logic               valid_r, valid_next_s;
  logic               pulse_r, pulse_next_s;

  logic [3:0]         search_req_s;
  logic [2:0]         pick_s;
  logic               pick_found_s;
  logic [1:0]         pick_idx_s;
  logic [WIDTH-1:0]   pick_value_s;
  logic               owner_live_s;
  logic [WIDTH-1:0]   owner_value_s;

  // Returns {found, index} of the first set bit scanning from p+1 upward with wrap.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (r[idx] && !res[2]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate selection; in OPEN the current owner is masked so a waiting requester wins.
  always_comb begin
    search_req_s  = (state_r == ST_OPEN) ? (req & ~grant_r) : req;
    pick_s        = rr_search(search_req_s, ptr_r);
    pick_found_s  = pick_s[2];
    pick_idx_s    = pick_s[1:0];
    pick_value_s  = req_value[int'(pick_idx_s)*WIDTH +: WIDTH];
    owner_live_s  = req[ptr_r];
    owner_value_s = req_value[int'(ptr_r)*WIDTH +: WIDTH];
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    ptr_next_s   = ptr_r;
    grant_next_s = grant_r;
    value_next_s = value_r;
    mode_next_s  = mode_r;
    valid_next_s = valid_r;
    pulse_next_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_next_s = ST_HOLD;
          cnt_next_s   = HOLD_LOAD;
          ptr_next_s   = pick_idx_s;
          grant_next_s = 4'b0001 << pick_idx_s;
          value_next_s = pick_value_s;
          mode_next_s  = req_mode[pick_idx_s];
          valid_next_s = 1'b1;
          pulse_next_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 32'd0) begin
          state_next_s = ST_OPEN;
        end else begin
          cnt_next_s = cnt_r - 32'd1;
        end
        // A dropped owner keeps the display but its last sampled value stays frozen.
        if (owner_live_s) begin
          value_next_s = owner_value_s;
          mode_next_s  = req_mode[ptr_r];
        end else begin
          value_next_s = value_r;
        end
      end
      ST_OPEN: begin
        if (pick_found_s) begin
          state_next_s = ST_HOLD;
          cnt_next_s   = HOLD_LOAD;
          ptr_next_s   = pick_idx_s;
          grant_next_s = 4'b0001 << pick_idx_s;
          value_next_s = pick_value_s;
          mode_next_s  = req_mode[pick_idx_s];
          valid_next_s = 1'b1;
          pulse_next_s = 1'b1;
        end else if (owner_live_s) begin
          value_next_s = owner_value_s;
          mode_next_s  = req_mode[ptr_r];
        end else begin
          state_next_s = ST_IDLE;
          grant_next_s = 4'b0000;
          valid_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        grant_next_s = 4'b0000;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 32'd0;
      ptr_r   <= 2'd3;
      grant_r <= 4'b0000;
      value_r <= '0;
      mode_r  <= 1'b1;
      valid_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ptr_r   <= ptr_next_s;
      grant_r <= grant_next_s;
      value_r <= value_next_s;
      mode_r  <= mode_next_s;
      valid_r <= valid_next_s;
      pulse_r <= pulse_next_s;
    end
  end

  assign grant        = grant_r;
  assign disp_value   = value_r;
  assign disp_mode    = mode_r;
  assign disp_valid   = valid_r;
  assign switch_pulse = pulse_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4.
module tb_seg_display_arbiter;

  localparam int WIDTH = 8;

  logic               clock;
  logic               reset;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] req_value;
  logic [3:0]         req_mode;
  logic [3:0]         grant;
  logic [WIDTH-1:0]   disp_value;
  logic               disp_mode;
  logic               disp_valid;
  logic               switch_pulse;

  int vec_cnt;
  int miss_cnt;
  int pulse_cnt;
  logic [3:0] exp_g;

  seg_display_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(32'd4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_value   (req_value),
    .req_mode    (req_mode),
    .grant       (grant),
    .disp_value  (disp_value),
    .disp_mode   (disp_mode),
    .disp_valid  (disp_valid),
    .switch_pulse(switch_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vec_cnt   = 0;
    miss_cnt  = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    req_value = 32'h0000_0000;
    req_mode  = 4'b0000;

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_value", 32'(disp_value), 32'h0);
    chk("rst_mode", 32'(disp_mode), 32'h1);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_pulse", 32'(switch_pulse), 32'h0);
    step();
    reset = 1'b0;

    // Single request with live value tracking, then drop to idle
    req = 4'b0001;
    req_value = 32'h0000_002A;
    step();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_pulse", 32'(switch_pulse), 32'h1);
    chk("single_value", 32'(disp_value), 32'h2A);
    chk("single_valid", 32'(disp_valid), 32'h1);
    chk("single_mode", 32'(disp_mode), 32'h0);
    req_value = 32'h0000_002B;
    step();
    chk("track_value", 32'(disp_value), 32'h2B);
    chk("track_pulse", 32'(switch_pulse), 32'h0);
    req = 4'b0000;
    req_value = 32'h0000_00EE;
    step(); step(); step();
    chk("single_open_grant", 32'(grant), 32'h1);
    chk("single_freeze", 32'(disp_value), 32'h2B);
    step();
    chk("single_idle_grant", 32'(grant), 32'h0);
    chk("single_idle_valid", 32'(disp_valid), 32'h0);
    chk("single_idle_value", 32'(disp_value), 32'h2B);
    chk("single_idle_pulse", 32'(switch_pulse), 32'h0);

    // Round robin with all four requesting
    do_reset();
    req_value = 32'h1312_1110;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      for (int c = 0; c < 5; c++) begin
        step();
        chk("rr_grant", 32'(grant), 32'(exp_g));
        chk("rr_pulse", 32'(switch_pulse), (c == 0) ? 32'h1 : 32'h0);
        chk("rr_value", 32'(disp_value), 32'h10 + 32'(i % 4));
      end
    end

    // No preemption during hold
    do_reset();
    req_value = 32'h0000_BBAA;
    req = 4'b0001;
    step();
    chk("np_grant0", 32'(grant), 32'h1);
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("np_hold", 32'(grant), 32'h1);
      chk("np_hold_pulse", 32'(switch_pulse), 32'h0);
    end
    step();
    chk("np_handover", 32'(grant), 32'h2);
    chk("np_handover_pulse", 32'(switch_pulse), 32'h1);
    chk("np_handover_value", 32'(disp_value), 32'hBB);

    // Early drop by owner 2
    do_reset();
    req_value = 32'h0077_0000;
    req = 4'b0100;
    step();
    chk("drop_grant", 32'(grant), 32'h4);
    chk("drop_value0", 32'(disp_value), 32'h77);
    req = 4'b0000;
    req_value = 32'h0055_0000;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("drop_hold_grant", 32'(grant), 32'h4);
      chk("drop_frozen", 32'(disp_value), 32'h77);
    end
    step();
    chk("drop_idle_grant", 32'(grant), 32'h0);
    chk("drop_idle_valid", 32'(disp_valid), 32'h0);
    chk("drop_idle_value", 32'(disp_value), 32'h77);

    // Sole owner persists; non-owner values are X
    do_reset();
    req_value = {8'h3C, {24{1'bx}}};
    req_mode  = 4'b1000;
    req = 4'b1000;
    pulse_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (switch_pulse === 1'b1) pulse_cnt++;
      chk("sole_grant", 32'(grant), 32'h8);
      chk("sole_valid", 32'(disp_valid), 32'h1);
      chk("sole_value", 32'(disp_value), 32'h3C);
      chk("sole_mode", 32'(disp_mode), 32'h1);
    end
    chk("sole_pulses", 32'(pulse_cnt), 32'h1);

    // Async reset in the middle of a hold
    do_reset();
    req_value = 32'h0000_9900;
    req_mode  = 4'b0000;
    req = 4'b0010;
    step();
    step();
    chk("ar_pre_grant", 32'(grant), 32'h2);
    chk("ar_pre_value", 32'(disp_value), 32'h99);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_value", 32'(disp_value), 32'h0);
    chk("ar_mode", 32'(disp_mode), 32'h1);
    chk("ar_valid", 32'(disp_valid), 32'h0);
    step();
    reset = 1'b0;
    chk("ar_held_grant", 32'(grant), 32'h0);
    step();
    chk("ar_regrant", 32'(grant), 32'h2);
    chk("ar_regrant_pulse", 32'(switch_pulse), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display path among four requesters, e.g. independent debounced switch counters.
- Grants one requester at a time with a guaranteed minimum on-screen hold time and round-robin fairness.
- Drives the value/mode inputs of the existing seven-segment FSM, and sits between the counters and the display driver.

Parameters:
- WIDTH, 8, bit width of each requester value and of the display value.
- HOLD_CYCLES, 100000000, minimum clock cycles a granted requester owns the display. Legal range 1 to 2^32-1; the bench uses 4.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester display request, level-sensitive; bit i belongs to requester i.
- req_value  input  4*WIDTH  requester values; requester i occupies bits [i*WIDTH +: WIDTH].
- req_mode  input  4  per-requester display mode bit, forwarded with the value.
- grant  output  4  one-hot current owner; all-zero when idle; registered.
- disp_value  output  WIDTH  value routed to the display FSM; registered.
- disp_mode  output  1  mode routed to the display FSM; registered.
- disp_valid  output  1  high while an owner exists; registered.
- switch_pulse  output  1  one-cycle pulse in the cycle grant takes a new nonzero value.

Behaviour:
- Reset (async assert, applies immediately):
  - grant=0, disp_value=0, disp_mode=1, disp_valid=0, switch_pulse=0.
  - State = IDLE, hold counter = 0, round-robin pointer = 3, so the first search starts at requester 0.
- Round-robin search: start at index (ptr+1) mod 4, wrap through all four, pick the first with req high. ptr := the granted index on every grant.
- IDLE:
  - If any req bit is high, then on the next edge: grant = search result, counter := HOLD_CYCLES-1, switch_pulse=1, disp_valid=1, go to HOLD.
  - Latency from req high to grant high is exactly 1 cycle.
- HOLD:
  - Each cycle, counter decrements.
  - When the counter is 0 at an edge, go to OPEN. With HOLD_CYCLES=1, HOLD lasts one cycle.
  - Data path while owner req=1: disp_value/disp_mode register the owner's live req_value/req_mode every cycle (1-cycle latency).
  - If owner req drops: disp_value/disp_mode freeze at the last sampled values, and ownership continues to the end of the hold.
  - Requests from others during HOLD are ignored; no preemption.
- OPEN (evaluated every cycle):
  - If any requester other than the owner has req=1: regrant via round-robin search, excluding the owner. Counter reload, switch_pulse=1, back to HOLD.
  - Else if owner req=1: stay OPEN. Same owner, live tracking continues, no pulse.
  - Else: go to IDLE. grant=0 and disp_valid=0 next cycle. disp_value/disp_mode retain their last values.
- Handover data: in the cycle the new grant appears, disp_value already carries the new owner's req_value sampled at that edge. There is no cycle showing a mix of owners.
- Invariants:
  - grant is always one-hot or zero.
  - switch_pulse is never high in two consecutive cycles unless HOLD_CYCLES=1.
  - switch_pulse is never high in IDLE.
- Reset mid-operation: immediate return to reset values, regardless of state or counter. The first grant after deassertion follows IDLE rules.
- Counter: 32-bit, loads HOLD_CYCLES-1, no wrap. The counter is only decremented in HOLD while nonzero.
- Not reset-sensitive: req_value/req_mode are purely sampled inputs, and X on a non-owner's value must not propagate.

Test Plan:
- Single request (HOLD_CYCLES=4): reset, then req=0001 with value0=8'h2A. Required response:
  - grant=0001, switch_pulse=1, disp_value=8'h2A, one cycle after req.
  - Change value0 to 8'h2B: disp_value=8'h2B next cycle.
- Round robin: req=1111 held continuously. Required grant sequence 0001, 0010, 0100, 1000, 0001, each held for exactly 5 cycles (4 HOLD + 1 OPEN). switch_pulse fires once per change.
- No preemption: owner 0 granted, then req1 rises 1 cycle later. Required: grant stays 0001 for the full 4-cycle hold, then becomes 0010 on the OPEN cycle.
- Early drop (owner 2, value 8'h77, req2 drops after 1 cycle, others idle). Required:
  - grant=0100 held until the hold expires, with disp_value frozen at 8'h77.
  - Then grant=0, disp_valid=0, disp_value stays 8'h77.
- Sole owner persists: only req3 high for 20 cycles. Required: grant=1000 the whole time, exactly one switch_pulse, disp_valid=1 throughout.
- Async reset mid-HOLD: assert reset between clock edges while grant=0010. Required:
  - grant=0, disp_value=0, disp_mode=1, disp_valid=0 immediately, without waiting for an edge.
  - After release with req=0010: grant=0010 after 1 cycle.
